// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Hazard/sequencing bundle between the RV32I datapath and pipeline_ctrl.
//   master : datapath side, drives hazard status and consumes the controls.
//   slave  : controller side (pipeline_ctrl).
// Signal suffixes are relative to the controller (_i into it, _o out of it).
//   ID_rs{1,2}_addr_i/_used_i  sources read by the instruction in ID
//   EX_rd_addr_i/EX_mem_read_i destination / load flag of the instruction in EX
//   EX_branch_taken_i          redirect resolved in EX
//   IF_imem_ready_i            fetch word valid this cycle
//   MEM_dmem_req_i/_ready_i    data access in MEM / completes this cycle
//   *_we_o, *_flush_o          pipeline register load enables / bubble loads
//   dmem_timeout_o             sticky data-memory timeout flag
//   stall_cycles_o, redirect_cnt_o  performance counters (0 when disabled)
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic [4:0]  ID_rs1_addr_i;
    logic [4:0]  ID_rs2_addr_i;
    logic        ID_rs1_used_i;
    logic        ID_rs2_used_i;
    logic [4:0]  EX_rd_addr_i;
    logic        EX_mem_read_i;
    logic        EX_branch_taken_i;
    logic        IF_imem_ready_i;
    logic        MEM_dmem_req_i;
    logic        MEM_dmem_ready_i;

    logic        pc_we_o;
    logic        IF_ID_we_o;
    logic        ID_EX_we_o;
    logic        EX_MEM_we_o;
    logic        IF_ID_flush_o;
    logic        ID_EX_flush_o;
    logic        MEM_WB_flush_o;
    logic        dmem_timeout_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] redirect_cnt_o;

    modport master (
        output ID_rs1_addr_i, ID_rs2_addr_i, ID_rs1_used_i, ID_rs2_used_i,
               EX_rd_addr_i, EX_mem_read_i, EX_branch_taken_i,
               IF_imem_ready_i, MEM_dmem_req_i, MEM_dmem_ready_i,
        input  pc_we_o, IF_ID_we_o, ID_EX_we_o, EX_MEM_we_o,
               IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o,
               dmem_timeout_o, stall_cycles_o, redirect_cnt_o
    );

    modport slave (
        input  ID_rs1_addr_i, ID_rs2_addr_i, ID_rs1_used_i, ID_rs2_used_i,
               EX_rd_addr_i, EX_mem_read_i, EX_branch_taken_i,
               IF_imem_ready_i, MEM_dmem_req_i, MEM_dmem_ready_i,
        output pc_we_o, IF_ID_we_o, ID_EX_we_o, EX_MEM_we_o,
               IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o,
               dmem_timeout_o, stall_cycles_o, redirect_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline. Resolves
// load-use hazards, EX redirects, instruction-fetch wait and data-memory wait
// with a 3-state FSM (RUN / DWAIT / REDIR) and flags over-long data waits.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; forces all enables/flushes to 0
//   bus    pipeline_ctrl_if.slave (hazard inputs, control outputs)
// Parameter:
//   DMEM_TIMEOUT  data-memory wait cycles before dmem_timeout_o sets (2..65535)
// Build option:
//   PIPE_CTRL_PERF_EN  adds stall_cycles_o / redirect_cnt_o counters;
//                      without it both read 0.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    localparam int             CW  = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO = CW'(DMEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, DWAIT, REDIR} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic           timeout_q, timeout_d;

    logic load_use, dwait, redir_take;
    logic pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, memwb_fl;

    assign load_use = bus.EX_mem_read_i && (bus.EX_rd_addr_i != 5'd0) &&
                      ((bus.ID_rs1_used_i && (bus.ID_rs1_addr_i == bus.EX_rd_addr_i)) ||
                       (bus.ID_rs2_used_i && (bus.ID_rs2_addr_i == bus.EX_rd_addr_i)));
    assign dwait    = bus.MEM_dmem_req_i && !bus.MEM_dmem_ready_i;

    // A redirect is accepted whenever the RUN rules apply (RUN, or DWAIT on
    // its completion cycle) and no data wait freezes the pipe.
    assign redir_take = bus.EX_branch_taken_i && !dwait && (state_q != REDIR);

    always_comb begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
        ifid_fl  = 1'b0;
        idex_fl  = 1'b0;
        memwb_fl = 1'b0;
        state_d  = state_q;

        if (dwait) begin
            // Freeze everything; MEM/WB gets a bubble so WB does not retire twice.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_fl = 1'b1;
            state_d  = DWAIT;
        end else if (state_q == REDIR) begin
            // EX holds the bubble from the redirect: branch/load-use are stale.
            if (!bus.IF_imem_ready_i) begin
                pc_we   = 1'b0;
                ifid_fl = 1'b1;
                state_d = REDIR;
            end else begin
                state_d = RUN;
            end
        end else begin
            // RUN, and DWAIT on the cycle its access completes.
            state_d = RUN;
            if (bus.EX_branch_taken_i) begin
                ifid_fl = 1'b1;
                idex_fl = 1'b1;
                state_d = REDIR;
            end else if (load_use) begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                idex_fl = 1'b1;
            end else if (!bus.IF_imem_ready_i) begin
                pc_we   = 1'b0;
                ifid_fl = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            ifid_fl  = 1'b0;
            idex_fl  = 1'b0;
            memwb_fl = 1'b0;
        end
    end

    // Every dwait cycle counts, including the one that enters DWAIT from RUN
    // or REDIR (the counter is always 0 there since it clears on !dwait).
    always_comb begin
        wcnt_d = '0;
        if (dwait)
            wcnt_d = (wcnt_q == TMO) ? wcnt_q : wcnt_q + CW'(1);
        timeout_d = timeout_q || (wcnt_d == TMO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_we_o        = pc_we;
    assign bus.IF_ID_we_o     = ifid_we;
    assign bus.ID_EX_we_o     = idex_we;
    assign bus.EX_MEM_we_o    = exmem_we;
    assign bus.IF_ID_flush_o  = ifid_fl;
    assign bus.ID_EX_flush_o  = idex_fl;
    assign bus.MEM_WB_flush_o = memwb_fl;
    assign bus.dmem_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, redir_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (!pc_we)     stall_q <= stall_q + 32'd1;
            if (redir_take) redir_q <= redir_q + 32'd1;
        end
    end

    assign bus.stall_cycles_o = stall_q;
    assign bus.redirect_cnt_o = redir_q;
`else
    logic unused_perf;
    assign unused_perf        = redir_take;
    assign bus.stall_cycles_o = '0;
    assign bus.redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
    localparam int T = 8;

    // Expected control vector: {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we,
    //                           IF_ID_flush, ID_EX_flush, MEM_WB_flush}
    localparam logic [6:0] DEF = 7'b1111_000;
    localparam logic [6:0] FRZ = 7'b0000_001;
    localparam logic [6:0] LU  = 7'b0011_010;
    localparam logic [6:0] BR  = 7'b1111_110;
    localparam logic [6:0] IMW = 7'b0111_100;
    localparam logic [6:0] OFF = 7'b0000_000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus();
    pipeline_ctrl #(.DMEM_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ld, br, im, rq, ry;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    bit          m_redir = 0;
    int          m_wait  = 0;
    bit          m_to    = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_rc    = 0;

    function automatic vec_t mk(input int rs1, input bit u1, input int rs2, input bit u2,
                                input int rd, input bit ld, input bit br, input bit im,
                                input bit rq, input bit ry, input logic [6:0] exp);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.u1 = u1; v.u2 = u2; v.ld = ld; v.br = br; v.im = im; v.rq = rq; v.ry = ry;
        v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ID_rs1_addr_i     = v.rs1;
        bus.ID_rs2_addr_i     = v.rs2;
        bus.ID_rs1_used_i     = v.u1;
        bus.ID_rs2_used_i     = v.u2;
        bus.EX_rd_addr_i      = v.rd;
        bus.EX_mem_read_i     = v.ld;
        bus.EX_branch_taken_i = v.br;
        bus.IF_imem_ready_i   = v.im;
        bus.MEM_dmem_req_i    = v.rq;
        bus.MEM_dmem_ready_i  = v.ry;
    endtask

    function automatic logic [6:0] obs();
        return {bus.pc_we_o, bus.IF_ID_we_o, bus.ID_EX_we_o, bus.EX_MEM_we_o,
                bus.IF_ID_flush_o, bus.ID_EX_flush_o, bus.MEM_WB_flush_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected controls straight from the priority rules.
    function automatic logic [6:0] m_exp();
        bit lu, dw;
        lu = bus.EX_mem_read_i && bus.EX_rd_addr_i != 0 &&
             ((bus.ID_rs1_used_i && bus.ID_rs1_addr_i == bus.EX_rd_addr_i) ||
              (bus.ID_rs2_used_i && bus.ID_rs2_addr_i == bus.EX_rd_addr_i));
        dw = bus.MEM_dmem_req_i && !bus.MEM_dmem_ready_i;
        if (!rst_n)                                return OFF;
        if (dw)                                    return FRZ;
        if (!m_redir && bus.EX_branch_taken_i)     return BR;
        if (!m_redir && lu)                        return LU;
        if (!bus.IF_imem_ready_i)                  return IMW;
        return DEF;
    endfunction

    task automatic m_step();
        bit dw;
        logic [6:0] e;
        dw = bus.MEM_dmem_req_i && !bus.MEM_dmem_ready_i;
        e  = m_exp();
        if (!rst_n) begin
            m_redir = 0; m_wait = 0; m_to = 0; m_stall = 0; m_rc = 0;
        end else begin
            if (!e[6]) m_stall++;
            if (!dw && !m_redir && bus.EX_branch_taken_i) m_rc++;
            if (dw) begin
                m_redir = 0;
                if (m_wait < T) m_wait++;
                if (m_wait == T) m_to = 1;
            end else begin
                m_wait  = 0;
                m_redir = m_redir ? !bus.IF_imem_ready_i : bus.EX_branch_taken_i;
            end
        end
    endtask

    // Advance one clock: model consumes this cycle's inputs, then the edge.
    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,1,0,0, DEF));
        #2;
        chk("reset_outputs", 32'(obs()), 32'(OFF));
        tick();
        rst_n = 1'b1;
    endtask

    task automatic perf_chk(input string nm, input logic [31:0] st, input logic [31:0] rc);
`ifdef PIPE_CTRL_PERF_EN
        chk({nm, "_stall"}, bus.stall_cycles_o, st);
        chk({nm, "_redir"}, bus.redirect_cnt_o, rc);
`else
        chk({nm, "_stall_off"}, bus.stall_cycles_o, 32'd0);
        chk({nm, "_redir_off"}, bus.redirect_cnt_o, 32'd0);
        if (st === 32'hx || rc === 32'hx) $display("unexpected x in model counters");
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,1,0,0, DEF);
        drive(idle);
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_timeout", 32'(bus.dmem_timeout_o), 32'd0);
        perf_chk("reset", 32'd0, 32'd0);

        // ---------------- table-driven sequence from RUN ----------------
        //           rs1 u1 rs2 u2 rd ld br im rq ry  exp
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, DEF));  // idle
        tbl.push_back(mk(5,1,0,0,5,1,0,1,0,0, LU ));  // load-use on rs1
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, DEF));  // next cycle default
        tbl.push_back(mk(0,1,0,0,0,1,0,1,0,0, DEF));  // rd = x0: no stall
        tbl.push_back(mk(1,0,7,0,7,1,0,1,0,0, DEF));  // rs2 match but unused
        tbl.push_back(mk(1,0,7,1,7,1,0,1,0,0, LU ));  // load-use on rs2
        tbl.push_back(mk(0,0,0,0,0,0,1,1,0,0, BR ));  // branch -> REDIR
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, DEF));  // REDIR, fetch ready
        tbl.push_back(mk(0,0,0,0,0,0,1,1,0,0, BR ));  // branch -> REDIR
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, IMW));  // 3 fetch bubbles
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, IMW));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, IMW));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, DEF));  // back to RUN
        tbl.push_back(mk(3,1,0,0,3,1,1,1,0,0, BR ));  // load-use + branch: branch wins
        tbl.push_back(mk(3,1,0,0,3,1,1,1,0,0, DEF));  // REDIR ignores both
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,1, DEF));  // access completes at once
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0, FRZ));  // 4 freeze cycles
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0, FRZ));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0, FRZ));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,1,0, FRZ));  // branch during wait frozen
        tbl.push_back(mk(0,0,0,0,0,0,1,1,1,1, BR ));  // completion + branch
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0, FRZ));  // dwait while in REDIR
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1, IMW));  // completes, RUN rules
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, IMW));  // still RUN
        tbl.push_back(mk(4,1,0,0,4,1,0,0,0,0, LU ));  // load-use over fetch wait
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, DEF));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
            tick();
        end

        // ---------------- timeout: ready low 10 cycles ----------------
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(mk(0,0,0,0,0,0,0,1,1,0, FRZ));
            #2;
            chk($sformatf("to_wait%0d", k), 32'(bus.dmem_timeout_o), 32'(k - 1 >= T));
            tick();
        end
        drive(mk(0,0,0,0,0,0,0,1,1,1, DEF));
        #2;
        chk("to_complete_out", 32'(obs()), 32'(DEF));
        chk("to_sticky1", 32'(bus.dmem_timeout_o), 32'd1);
        tick();
        drive(idle);
        #2;
        chk("to_sticky2", 32'(bus.dmem_timeout_o), 32'd1);
        tick();
        do_reset();
        chk("to_cleared", 32'(bus.dmem_timeout_o), 32'd0);

        // ---------------- reset in the middle of DWAIT ----------------
        for (int k = 0; k < 5; k++) begin
            drive(mk(0,0,0,0,0,0,0,1,1,0, FRZ));
            tick();
        end
        rst_n = 1'b0;
        #2;
        chk("rst_dwait_out", 32'(obs()), 32'(OFF));
        tick();
        rst_n = 1'b1;
        #2;
        chk("post_rst_freeze", 32'(obs()), 32'(FRZ));
        // counter restarted: 7 more wait cycles stay below the limit
        for (int k = 0; k < 7; k++) tick();
        #2;
        chk("post_rst_no_timeout", 32'(bus.dmem_timeout_o), 32'd0);
        drive(idle);
        #2;
        chk("post_rst_run", 32'(obs()), 32'(DEF));
        tick();

        // ---------------- perf counters ----------------
        do_reset();
        drive(mk(5,1,0,0,5,1,0,1,0,0, LU)); tick();
        drive(idle);                          tick();
        drive(mk(0,0,0,0,0,0,1,1,0,0, BR));   tick();
        drive(idle);                          tick();
        for (int k = 0; k < 3; k++) begin
            drive(mk(0,0,0,0,0,0,0,1,1,0, FRZ)); tick();
        end
        drive(mk(0,0,0,0,0,0,0,1,1,1, DEF));  tick();
        drive(idle);                          #2;
        perf_chk("perf", 32'd4, 32'd1);
        tick();

        // ---------------- randomized against the model ----------------
        for (int c = 0; c < 3000; c++) begin
            vec_t v;
            rst_n = ($urandom_range(0, 199) != 0);
            v = mk($urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,3),
                   $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,9) < 4,
                   $urandom_range(0,9) < 2, $urandom_range(0,9) < 8,
                   $urandom_range(0,9) < 4, $urandom_range(0,9) < 3, DEF);
            drive(v);
            #2;
            chk($sformatf("rnd%0d_ctl", c), 32'(obs()), 32'(m_exp()));
            chk($sformatf("rnd%0d_to", c), 32'(bus.dmem_timeout_o), 32'(m_to));
            perf_chk($sformatf("rnd%0d", c), m_stall, m_rc);
            tick();
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. Drives write-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch/jump redirects, instruction-memory wait and data-memory wait through a small FSM, and watches data-memory waits with a timeout.

## Interface
- DMEM_TIMEOUT, 256: data-memory wait cycles before the timeout flag sets (range 2..65535).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ID_rs1_addr_i / ID_rs2_addr_i  in  5  source registers of the instruction in ID.
- ID_rs1_used_i / ID_rs2_used_i  in  1  source actually read by that instruction.
- EX_rd_addr_i  in  5  destination of the instruction in EX.
- EX_mem_read_i  in  1  instruction in EX is a load.
- EX_branch_taken_i  in  1  redirect resolved in EX; the PC mux selects the target.
- IF_imem_ready_i  in  1  instruction word on IF is valid this cycle.
- MEM_dmem_req_i / MEM_dmem_ready_i  in  1  data access in MEM / access completes this cycle.
- pc_we_o, IF_ID_we_o, ID_EX_we_o, EX_MEM_we_o  out  1  register load enables.
- IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o  out  1  load a bubble (all-zero/NOP) instead of data.
- dmem_timeout_o  out  1  sticky timeout flag.
- stall_cycles_o, redirect_cnt_o  out  32  performance counters. Present only under the macro, see Configuration.

## Operation
- Definitions:
  - load_use = EX_mem_read_i & (EX_rd_addr_i!=0) & ((ID_rs1_used_i & rs1==rd) | (ID_rs2_used_i & rs2==rd)).
  - dwait = MEM_dmem_req_i & !MEM_dmem_ready_i.
- Default outputs: every *_we_o = 1 and every *_flush_o = 0.
- FSM states: RUN, DWAIT, REDIR. Outputs are Mealy (state + current inputs). Priority is applied top-down.
- RUN:
  - dwait: freeze the pipeline. All *_we_o = 0 and MEM_WB_flush_o = 1. Next state DWAIT.
  - EX_branch_taken_i: pc_we_o = 1, IF_ID_flush_o = 1, ID_EX_flush_o = 1. Next state REDIR.
  - load_use: pc_we_o = 0, IF_ID_we_o = 0, ID_EX_flush_o = 1. Stay in RUN.
  - !IF_imem_ready_i: pc_we_o = 0, IF_ID_flush_o = 1. Stay in RUN.
- DWAIT:
  - While dwait: same freeze outputs. The wait counter increments, saturating at DMEM_TIMEOUT. When it equals DMEM_TIMEOUT, dmem_timeout_o sets.
  - When !dwait: counter clears and the state returns to RUN. The same cycle's outputs are evaluated by the RUN rules, so a completing access and a branch are handled together.
- REDIR:
  - EX holds a bubble, so EX_branch_taken_i and load_use are ignored.
  - dwait: same as RUN, next state DWAIT.
  - !IF_imem_ready_i: pc_we_o = 0, IF_ID_flush_o = 1. Stay in REDIR.
  - Otherwise: default outputs. Next state RUN.
- dmem_timeout_o is cleared only by reset. The pipeline keeps waiting after timeout; no abort.

## Timing
- Reset (rst_n=0 at an edge):
  - State becomes RUN, wait counter 0, dmem_timeout_o 0, perf counters 0.
  - While rst_n is low, every *_we_o and *_flush_o is 0.
- Control outputs are combinational: zero-cycle latency from inputs. No input is registered.
- Load-use costs exactly 1 bubble.
- A taken redirect costs 2 squashed instructions, plus 1 bubble per cycle the target fetch is not ready.
- Wait counter width is clog2(DMEM_TIMEOUT+1). It never wraps.
- Reset mid-DWAIT or mid-REDIR goes straight to RUN with no pending action.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles_o counts every non-reset cycle with pc_we_o = 0.
  - redirect_cnt_o counts RUN-state cycles with EX_branch_taken_i that are taken as redirects.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: no counter registers exist and both ports are tied to 0.

## Test plan
- rs1 = x5 in ID, load with rd = x5 in EX -> one cycle with pc_we_o = 0, IF_ID_we_o = 0, ID_EX_flush_o = 1; the next cycle is default. Same stimulus with rd = x0 -> no stall.
- EX_branch_taken_i pulse with imem ready -> IF_ID_flush_o = ID_EX_flush_o = 1 for 1 cycle, REDIR for 1 cycle, then RUN. Hold imem not-ready 3 cycles in REDIR -> 3 bubble cycles.
- MEM_dmem_req_i with ready low for 4 cycles -> 4 freeze cycles (all we 0, MEM_WB_flush_o 1). Branch asserted on the completion cycle -> redirect outputs on that same cycle.
- DMEM_TIMEOUT = 8, ready held low 10 cycles -> dmem_timeout_o rises after the 8th wait cycle. It stays 1 after completion until rst_n pulse.
- Load-use and branch asserted together in RUN -> branch wins. Reset asserted during DWAIT -> next cycle state RUN with all flags 0.
- With PIPE_CTRL_PERF_EN: 1 load-use, 1 redirect, 3-cycle dmem wait -> stall_cycles_o = 4, redirect_cnt_o = 1. Without the macro, both ports read 0.
